data_mem_arbiter: RTL

//  Shares the single data-memory port between the processor Memory stage (cpu) and an external

---
 rtl/arb_pkg.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/data_mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package arb_pkg;

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned BURST_LEN_DEF  = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W   = 3,
  parameter int unsigned MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] LP_MAX = W'(MAX);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (inc && (r_q != LP_MAX)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter: cpu has priority, a starvation counter forces
// bounded host bursts during which the pipeline is stalled.
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [SW-1:0] LP_STARVE_LAST = SW'(STARVE_MAX - 1);
  localparam logic [BW-1:0] LP_BURST_LAST  = BW'(BURST_LEN - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_stall;
  logic              w_cpu_gnt;
  logic              w_host_gnt;
  logic              w_enter;
  logic [SW-1:0]     w_starve;
  logic [BW-1:0]     w_burst;
  logic              r_rd_pend;
  owner_t            r_rd_owner;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  logic              w_cpu_load;
  logic              w_host_load;
  logic              w_cpu_rvalid;
  logic              w_host_rvalid;

  sat_counter #(.W(SW), .MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (host_req && !w_host_gnt && !rst),
    .clr (w_host_gnt || w_enter),
    .q   (w_starve)
  );

  sat_counter #(.W(BW), .MAX(BURST_LEN)) u_burst (
    .clk (clk),
    .rst (rst),
    .inc (w_host_gnt && (r_state == S_HOST)),
    .clr (w_enter),
    .q   (w_burst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CPU;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= (w_state_nxt == S_HOST);
    end
  end

  // Grants are suppressed while rst is high so every output reads 0 in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_gnt   = 1'b0;
    w_host_gnt  = 1'b0;
    w_enter     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_CPU: begin
          if (cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (host_req) begin
            w_host_gnt = 1'b1;
          end
          if (host_req && !w_host_gnt && (w_starve == LP_STARVE_LAST)) begin
            w_state_nxt = S_HOST;
            w_enter     = 1'b1;
          end
        end
        S_HOST: begin
          if (host_req) begin
            w_host_gnt = 1'b1;
            if (w_burst == LP_BURST_LAST) begin
              w_state_nxt = S_CPU;
            end
          end else begin
            w_state_nxt = S_CPU;
          end
        end
        default: w_state_nxt = S_CPU;
      endcase
    end
  end

  assign w_cpu_load  = w_cpu_gnt && !cpu_we;
  assign w_host_load = w_host_gnt && !host_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= OWN_CPU;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_rd_pend  <= w_cpu_load || w_host_load;
      r_rd_owner <= w_host_load ? OWN_HOST : OWN_CPU;
      if (w_cpu_rvalid) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (w_host_rvalid) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

  assign w_cpu_rvalid  = !rst && r_rd_pend && (r_rd_owner == OWN_CPU);
  assign w_host_rvalid = !rst && r_rd_pend && (r_rd_owner == OWN_HOST);

  assign cpu_stall   = r_stall;
  assign cpu_rvalid  = w_cpu_rvalid;
  assign host_rvalid = w_host_rvalid;
  assign host_gnt    = w_host_gnt;
  assign cpu_rdata   = rst ? '0 : (w_cpu_rvalid ? mem_rdata : r_cpu_rdata);
  assign host_rdata  = rst ? '0 : (w_host_rvalid ? mem_rdata : r_host_rdata);

  assign mem_we    = (w_cpu_gnt && cpu_we) || (w_host_gnt && host_we);
  assign mem_addr  = rst ? '0 : (w_host_gnt ? host_addr : cpu_addr);
  assign mem_wdata = rst ? '0 : (w_host_gnt ? host_wdata : cpu_wdata);

endmodule
